memex_writeback_unit: RTL and testbench

Final execution stage of the RV32E pipeline, consuming the MEMPREP→MEMEX register outputs. Waits for the data-memory read response on loads and performs byte/half extraction with sign/zero extension. Selects the write-back value and drives a registered register-file write port. Asserts a stall toward the hazard unit while a load response is outstanding, and reports loads that time out or are misaligned.

---
 rtl/rv32e_pkg.sv | 33 +++
 rtl/memex_writeback_unit_load_align.sv | 41 ++++
 rtl/memex_writeback_unit.sv | 145 ++++++++++++++
 tb/tb_memex_writeback_unit.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv32e_pkg.sv
// Shared RV32E pipeline types for the MEMEX write-back stage.
package rv32e_pkg;

    typedef enum logic [1:0] {
        RD_SEL_ALU  = 2'd0,
        RD_SEL_LOAD = 2'd1,
        RD_SEL_PC4  = 2'd2,
        RD_SEL_IMM  = 2'd3
    } rd_data_sel_t;

    typedef enum logic [1:0] {
        WIDTH_BYTE = 2'd0,
        WIDTH_HALF = 2'd1,
        WIDTH_WORD = 2'd2
    } data_width_t;

    typedef enum logic {
        MEMEX_IDLE = 1'b0,
        MEMEX_WAIT = 1'b1
    } memex_state_t;

    // Reserved width encoding 3 behaves like a word access.
    function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] offset);
        logic mis;
        case (width)
            WIDTH_BYTE: mis = 1'b0;
            WIDTH_HALF: mis = offset[0];
            default:    mis = (offset != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/memex_writeback_unit_load_align.sv
// Combinational byte/half/word extraction from an aligned read word, with sign or zero extension.
module load_align
    import rv32e_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [1:0]  width,
    input  logic        sign_extend,
    output logic [31:0] data
);
    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Pick the addressed byte and half-word lanes.
    always_comb begin
        byte_s = 8'h00;
        case (offset)
            2'd0:    byte_s = rdata[7:0];
            2'd1:    byte_s = rdata[15:8];
            2'd2:    byte_s = rdata[23:16];
            2'd3:    byte_s = rdata[31:24];
            default: byte_s = 8'h00;
        endcase
        if (offset[1]) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end
    end

    // Extend the selected lane to 32 bits.
    always_comb begin
        data = rdata;
        case (width)
            WIDTH_BYTE: data = sign_extend ? {{24{byte_s[7]}}, byte_s} : {24'h000000, byte_s};
            WIDTH_HALF: data = sign_extend ? {{16{half_s[15]}}, half_s} : {16'h0000, half_s};
            default:    data = rdata;
        endcase
    end

endmodule

// File: rtl/memex_writeback_unit.sv
// MEMEX write-back stage: waits for load data, selects the write-back value and drives a
// registered register-file write port, stalling upstream and flagging load faults.
module memex_writeback_unit
    import rv32e_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        invalid_MEMEX,
    input  logic [31:0] pc4_MEMEX,
    input  logic [3:0]  rd_MEMEX,
    input  logic [31:0] alu_result_MEMEX,
    input  logic        regfile_we_MEMEX,
    input  logic [1:0]  rd_data_sel_MEMEX,
    input  logic        lsu_sign_extend_MEMEX,
    input  logic [1:0]  data_width_MEMEX,
    input  logic [31:0] immediate_MEMEX,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        stall_MEMEX,
    output logic        regfile_we,
    output logic [3:0]  regfile_waddr,
    output logic [31:0] regfile_wdata,
    output logic        load_fault
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE_C = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO_C = CNT_W'(0);
    localparam logic [0:0] ST_IDLE = MEMEX_IDLE;
    localparam logic [0:0] ST_WAIT = MEMEX_WAIT;

    logic [0:0]       state_r, state_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic             live_s, load_s, misaligned_s, aligned_load_s;
    logic             complete_s, fault_s, stall_s, write_s;
    logic [31:0]      load_data_s, wb_data_s;
    logic             regfile_we_r, load_fault_r;
    logic [3:0]       regfile_waddr_r;
    logic [31:0]      regfile_wdata_r;

    assign live_s         = !invalid_MEMEX && regfile_we_MEMEX;
    assign load_s         = live_s && (rd_data_sel_MEMEX == RD_SEL_LOAD);
    assign misaligned_s   = load_s && is_misaligned(data_width_MEMEX, alu_result_MEMEX[1:0]);
    assign aligned_load_s = load_s && !misaligned_s;

    load_align u_load_align (
        .rdata       (dmem_rdata),
        .offset      (alu_result_MEMEX[1:0]),
        .width       (data_width_MEMEX),
        .sign_extend (lsu_sign_extend_MEMEX),
        .data        (load_data_s)
    );

    // Load-wait FSM: decides completion, fault, stall and the next counter value.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        complete_s  = 1'b0;
        fault_s     = 1'b0;
        stall_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (misaligned_s) begin
                    fault_s = 1'b1;
                end else if (aligned_load_s) begin
                    if (dmem_rvalid) begin
                        complete_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_WAIT;
                        cnt_nxt_s   = CNT_ONE_C;
                        stall_s     = 1'b1;
                    end
                end else begin
                    complete_s = live_s;
                end
            end
            ST_WAIT: begin
                // Upstream holds the load steady here, so the live inputs are still the load.
                if (dmem_rvalid) begin
                    complete_s  = 1'b1;
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = CNT_ZERO_C;
                end else if (cnt_r >= TIMEOUT_C) begin
                    fault_s     = 1'b1;
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = CNT_ZERO_C;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE_C;
                    stall_s   = 1'b1;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = CNT_ZERO_C;
            end
        endcase
    end

    // Write-back source select.
    always_comb begin
        wb_data_s = alu_result_MEMEX;
        case (rd_data_sel_MEMEX)
            RD_SEL_ALU:  wb_data_s = alu_result_MEMEX;
            RD_SEL_LOAD: wb_data_s = load_data_s;
            RD_SEL_PC4:  wb_data_s = pc4_MEMEX;
            RD_SEL_IMM:  wb_data_s = immediate_MEMEX;
            default:     wb_data_s = alu_result_MEMEX;
        endcase
    end

    assign write_s     = complete_s && (rd_MEMEX != 4'd0);
    assign stall_MEMEX = stall_s;

    // FSM state, timeout counter and registered write-back/fault outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= ST_IDLE;
            cnt_r           <= CNT_ZERO_C;
            regfile_we_r    <= 1'b0;
            regfile_waddr_r <= 4'd0;
            regfile_wdata_r <= 32'h0000_0000;
            load_fault_r    <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            cnt_r        <= cnt_nxt_s;
            regfile_we_r <= write_s;
            load_fault_r <= fault_s;
            if (write_s) begin
                regfile_waddr_r <= rd_MEMEX;
                regfile_wdata_r <= wb_data_s;
            end else begin
                regfile_waddr_r <= regfile_waddr_r;
                regfile_wdata_r <= regfile_wdata_r;
            end
        end
    end

    assign regfile_we    = regfile_we_r;
    assign regfile_waddr = regfile_waddr_r;
    assign regfile_wdata = regfile_wdata_r;
    assign load_fault    = load_fault_r;

endmodule

// File: tb/tb_memex_writeback_unit.sv
// Randomized bench for memex_writeback_unit against a transaction-level model of each instruction.
module tb_memex_writeback_unit;
    localparam int T = 4;
    localparam int N = 8192;

    typedef struct {
        bit          inv;
        logic [31:0] pc4;
        logic [3:0]  rd;
        logic [31:0] alu;
        bit          we;
        logic [1:0]  sel;
        bit          sx;
        logic [1:0]  w;
        logic [31:0] imm;
    } instr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        invalid_MEMEX = 1'b1;
    logic [31:0] pc4_MEMEX = 32'h0;
    logic [3:0]  rd_MEMEX = 4'h0;
    logic [31:0] alu_result_MEMEX = 32'h0;
    logic        regfile_we_MEMEX = 1'b0;
    logic [1:0]  rd_data_sel_MEMEX = 2'd0;
    logic        lsu_sign_extend_MEMEX = 1'b0;
    logic [1:0]  data_width_MEMEX = 2'd0;
    logic [31:0] immediate_MEMEX = 32'h0;
    logic        dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = 32'h0;
    logic        stall_MEMEX, regfile_we, load_fault;
    logic [3:0]  regfile_waddr;
    logic [31:0] regfile_wdata;

    always #5 clk = ~clk;

    memex_writeback_unit #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst), .invalid_MEMEX(invalid_MEMEX), .pc4_MEMEX(pc4_MEMEX),
        .rd_MEMEX(rd_MEMEX), .alu_result_MEMEX(alu_result_MEMEX),
        .regfile_we_MEMEX(regfile_we_MEMEX), .rd_data_sel_MEMEX(rd_data_sel_MEMEX),
        .lsu_sign_extend_MEMEX(lsu_sign_extend_MEMEX), .data_width_MEMEX(data_width_MEMEX),
        .immediate_MEMEX(immediate_MEMEX), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .stall_MEMEX(stall_MEMEX), .regfile_we(regfile_we), .regfile_waddr(regfile_waddr),
        .regfile_wdata(regfile_wdata), .load_fault(load_fault)
    );

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int cc;
    bit          chk_s [N];
    bit          chk_o [N];
    bit          chk_d [N];
    bit          e_stall [N];
    bit          e_we [N];
    bit          e_fault [N];
    logic [3:0]  e_waddr [N];
    logic [31:0] e_wdata [N];

    always @(posedge clk) cyc <= cyc + 1;

    // Compare DUT against the expectations recorded for this cycle.
    always @(negedge clk) begin
        cc = cyc;
        if (chk_s[cc]) begin
            checks++;
            if (stall_MEMEX !== e_stall[cc]) begin
                failures++;
                $display("FAIL stall cyc=%0d got=%b exp=%b", cc, stall_MEMEX, e_stall[cc]);
            end
        end
        if (chk_o[cc]) begin
            checks++;
            if (regfile_we !== e_we[cc]) begin
                failures++;
                $display("FAIL regfile_we cyc=%0d got=%b exp=%b", cc, regfile_we, e_we[cc]);
            end
            checks++;
            if (load_fault !== e_fault[cc]) begin
                failures++;
                $display("FAIL load_fault cyc=%0d got=%b exp=%b", cc, load_fault, e_fault[cc]);
            end
            if (chk_d[cc]) begin
                checks++;
                if (regfile_waddr !== e_waddr[cc] || regfile_wdata !== e_wdata[cc]) begin
                    failures++;
                    $display("FAIL wb_data cyc=%0d got=%0d/%h exp=%0d/%h", cc,
                             regfile_waddr, regfile_wdata, e_waddr[cc], e_wdata[cc]);
                end
            end
        end
    end

    function automatic int access_size(input logic [1:0] w);
        return (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
    endfunction

    // Reference extraction: shift the addressed bytes down, mask, then extend.
    function automatic logic [31:0] extract(input logic [31:0] rdata, input logic [1:0] off,
                                            input logic [1:0] w, input bit sx);
        logic [31:0] v;
        int n;
        n = access_size(w);
        if (n == 4) return rdata;
        v = rdata >> (8 * int'(off));
        v = v & ((32'h1 << (8 * n)) - 32'h1);
        if (sx && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic apply(input instr_t ins, input bit rv, input logic [31:0] rdw);
        invalid_MEMEX         = ins.inv;
        pc4_MEMEX             = ins.pc4;
        rd_MEMEX              = ins.rd;
        alu_result_MEMEX      = ins.alu;
        regfile_we_MEMEX      = ins.we;
        rd_data_sel_MEMEX     = ins.sel;
        lsu_sign_extend_MEMEX = ins.sx;
        data_width_MEMEX      = ins.w;
        immediate_MEMEX       = ins.imm;
        dmem_rvalid           = rv;
        dmem_rdata            = rdw;
    endtask

    // One cycle of stimulus plus the expected stall now and outputs one cycle later.
    task automatic step(input instr_t ins, input bit rv, input logic [31:0] rdw, input bit es,
                        input bit ewe, input logic [31:0] ewd, input bit ef);
        @(posedge clk); #1;
        rst = 1'b0;
        apply(ins, rv, rdw);
        chk_s[cyc] = 1'b1;  e_stall[cyc] = es;
        chk_o[cyc + 1] = 1'b1;  chk_d[cyc + 1] = ewe;
        e_we[cyc + 1] = ewe;  e_fault[cyc + 1] = ef;
        e_waddr[cyc + 1] = ins.rd;  e_wdata[cyc + 1] = ewd;
    endtask

    task automatic rst_step(input instr_t ins, input bit rv);
        @(posedge clk); #1;
        rst = 1'b1;
        apply(ins, rv, $urandom);
        chk_s[cyc] = 1'b0;
        chk_o[cyc + 1] = 1'b1;  chk_d[cyc + 1] = 1'b1;
        e_we[cyc + 1] = 1'b0;  e_fault[cyc + 1] = 1'b0;
        e_waddr[cyc + 1] = 4'd0;  e_wdata[cyc + 1] = 32'h0;
    endtask

    // Whole instruction: held for min(lat,T)+1 cycles if it is an aligned live load.
    task automatic issue(input instr_t ins, input int lat, input logic [31:0] rdw);
        bit live, load, mis;
        logic [31:0] val;
        live = !ins.inv && ins.we;
        load = live && (ins.sel == 2'd1);
        mis  = load && ((int'(ins.alu[1:0]) % access_size(ins.w)) != 0);
        if (!load || mis) begin
            val = (ins.sel == 2'd2) ? ins.pc4 : (ins.sel == 2'd3) ? ins.imm : ins.alu;
            step(ins, 1'($urandom), $urandom, 1'b0, live && !load && ins.rd != 4'd0, val, mis);
        end else if (lat <= T) begin
            for (int k = 0; k < lat; k++) step(ins, 1'b0, $urandom, 1'b1, 1'b0, 32'h0, 1'b0);
            step(ins, 1'b1, rdw, 1'b0, ins.rd != 4'd0, extract(rdw, ins.alu[1:0], ins.w, ins.sx), 1'b0);
        end else begin
            for (int k = 0; k < T; k++) step(ins, 1'b0, $urandom, 1'b1, 1'b0, 32'h0, 1'b0);
            step(ins, 1'b0, $urandom, 1'b0, 1'b0, 32'h0, 1'b1);
        end
    endtask

    function automatic instr_t mk(input bit inv, input logic [3:0] rd, input logic [31:0] alu,
                                  input bit we, input logic [1:0] sel, input bit sx,
                                  input logic [1:0] w);
        instr_t i;
        i.inv = inv;  i.pc4 = $urandom;  i.rd = rd;  i.alu = alu;  i.we = we;
        i.sel = sel;  i.sx = sx;  i.w = w;  i.imm = $urandom;
        return i;
    endfunction

    function automatic instr_t rand_instr();
        return mk($urandom_range(0, 7) == 0, 4'($urandom), $urandom, $urandom_range(0, 7) != 0,
                  ($urandom_range(0, 1) == 1) ? 2'd1 : 2'($urandom), 1'($urandom), 2'($urandom));
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        instr_t bub;
        bub = mk(1'b1, 4'd7, 32'h0, 1'b1, 2'd0, 1'b0, 2'd0);
        rst_step(bub, 1'b1);
        rst_step(bub, 1'b1);
        step(bub, 1'b1, $urandom, 1'b0, 1'b0, 32'h0, 1'b0);

        // Pin the reference extraction to hand-computed values.
        check_val("model_sbyte", extract(32'h80FF_0000, 2'd3, 2'd0, 1'b1), 32'hFFFF_FF80);
        check_val("model_ubyte", extract(32'h80FF_0000, 2'd3, 2'd0, 1'b0), 32'h0000_0080);
        check_val("model_shalf", extract(32'hBEEF_0000, 2'd2, 2'd1, 1'b1), 32'hFFFF_BEEF);

        // ALU write with a literal expectation.
        step(mk(1'b0, 4'd5, 32'h0000_1234, 1'b1, 2'd0, 1'b0, 2'd0), 1'b0, 32'h0,
             1'b0, 1'b1, 32'h0000_1234, 1'b0);
        issue(mk(1'b0, 4'd3, 32'h0000_1003, 1'b1, 2'd1, 1'b1, 2'd0), 0, 32'h80FF_0000);
        issue(mk(1'b0, 4'd4, 32'h0000_1003, 1'b1, 2'd1, 1'b0, 2'd0), 0, 32'h80FF_0000);
        issue(mk(1'b0, 4'd6, 32'h0000_2002, 1'b1, 2'd1, 1'b1, 2'd1), 4, 32'hBEEF_0000);
        issue(mk(1'b0, 4'd8, 32'h0000_3000, 1'b1, 2'd1, 1'b0, 2'd2), T + 3, 32'h0);
        issue(mk(1'b0, 4'd9, 32'h0000_4002, 1'b1, 2'd1, 1'b0, 2'd2), 0, 32'h0);
        issue(mk(1'b1, 4'd9, 32'h0000_4002, 1'b1, 2'd1, 1'b0, 2'd2), 0, 32'h0);
        issue(mk(1'b0, 4'd0, 32'h0000_5555, 1'b1, 2'd0, 1'b0, 2'd0), 0, 32'h0);
        issue(mk(1'b0, 4'd0, 32'h0000_5000, 1'b1, 2'd1, 1'b0, 2'd2), 2, 32'h1234_5678);
        for (int k = 0; k < 3; k++)
            issue(mk(1'b0, 4'(k + 10), 32'h0000_6000 + 32'(k), 1'b1, 2'd1, 1'b1, 2'd0), 0, $urandom);

        // Reset in the middle of a load wait, then a stray rvalid under a bubble.
        step(mk(1'b0, 4'd2, 32'h0000_7000, 1'b1, 2'd1, 1'b0, 2'd2), 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        step(mk(1'b0, 4'd2, 32'h0000_7000, 1'b1, 2'd1, 1'b0, 2'd2), 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        rst_step(mk(1'b0, 4'd2, 32'h0000_7000, 1'b1, 2'd1, 1'b0, 2'd2), 1'b0);
        step(bub, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 1'b0);
        step(bub, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 1'b0);

        for (int n = 0; n < 400; n++) issue(rand_instr(), $urandom_range(0, T + 2), $urandom);

        step(bub, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        step(bub, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
